// File: rtl/npc_pkg.sv
// npc_pkg: shared fetch-stage types and constants.
package npc_pkg;
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_VALID, S_NPC, S_FAULT} ifu_state_e;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [1:0] INST_ALIGN_MASK = 2'b11;
    function automatic logic misaligned(input logic [1:0] lsb);
        return (lsb & INST_ALIGN_MASK) != 2'b00;
    endfunction
endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction-memory request/response bus between fetch and memory.
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  imem_rsp_err;
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
    );
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
    );
endinterface

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: two free-running wrap-around event counters with enables.
module ifu_perf_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic                 stall_en,
    output logic [CNT_WIDTH-1:0] fetch_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);
    logic [CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + CNT_WIDTH'(fetch_en);
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(stall_en);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC register and fetch FSM; one outstanding imem request, hands {pc, inst} to decode.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = npc_pkg::RESET_PC,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ifu_fetch_if.master           imem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    input  logic                  dnpc_valid,
    input  logic [ADDR_WIDTH-1:0] dnpc,
    output logic                  fetch_fault,
    output logic [ADDR_WIDTH-1:0] fault_pc,
    output logic [CNT_WIDTH-1:0]  fetch_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    import npc_pkg::*;
    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, fault_pc_q, fault_pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  npc_take, npc_bad, rsp_ok, rsp_bad;
    always_comb begin
        npc_take   = dnpc_valid & (((state_q == S_VALID) & out_ready) | (state_q == S_NPC));
        npc_bad    = misaligned(dnpc[1:0]);
        rsp_ok     = (state_q == S_WAIT) & imem.imem_rsp_valid & ~imem.imem_rsp_err;
        rsp_bad    = (state_q == S_WAIT) & imem.imem_rsp_valid & imem.imem_rsp_err;
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = rsp_ok ? imem.imem_rsp_data : inst_q;
        fault_pc_d = rsp_bad ? pc_q : fault_pc_q;
        case (state_q)
            S_REQ:          state_d = imem.imem_req_ready ? S_WAIT : S_REQ;
            S_WAIT:         state_d = rsp_bad ? S_FAULT : (rsp_ok ? S_VALID : S_WAIT);
            S_VALID:        state_d = out_ready ? S_NPC : S_VALID;
            S_NPC, S_FAULT: state_d = state_q;
            default:        state_d = S_FAULT;
        endcase
        // A misaligned target faults without disturbing the architectural PC.
        if (npc_take) begin
            state_d    = npc_bad ? S_FAULT : S_REQ;
            pc_d       = npc_bad ? pc_q : dnpc;
            fault_pc_d = npc_bad ? dnpc : fault_pc_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            fault_pc_q <= fault_pc_d;
        end
    end
    assign imem.imem_req_valid = (state_q == S_REQ) & ~rst;
    assign imem.imem_req_addr  = pc_q;
    assign out_valid           = (state_q == S_VALID) & ~rst;
    assign pc                  = pc_q;
    assign inst                = inst_q;
    assign fetch_fault         = state_q == S_FAULT;
    assign fault_pc            = fault_pc_q;
    ifu_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (out_valid & out_ready),
        .stall_en  (((state_q == S_WAIT) & ~imem.imem_rsp_valid) | ((state_q == S_VALID) & ~out_ready)),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios against a latency-configurable instruction memory model.
module tb_ifu_fetch;
    localparam logic [31:0] RPC = 32'h8000_0000;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_valid, out_ready, dnpc_valid, fetch_fault;
    logic [31:0] pc, inst, dnpc, fault_pc, fetch_cnt, stall_cnt;
    int          compared = 0;
    int          mismatched = 0;
    int          lat = 1;
    bit          err_en = 1'b0;
    bit          stray = 1'b0;
    logic [31:0] err_addr = '0;
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    ifu_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem ();

    ifu_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pc          (pc),
        .inst        (inst),
        .dnpc_valid  (dnpc_valid),
        .dnpc        (dnpc),
        .fetch_fault (fetch_fault),
        .fault_pc    (fault_pc),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h13 + ((a & 32'hffff) << 12);
    endfunction

    // Memory: response appears lat cycles after the accepting edge; reset drops it.
    always @(posedge clk) begin
        imem.imem_rsp_valid <= 1'b0;
        imem.imem_rsp_err   <= 1'b0;
        if (rst) begin
            pending <= 1'b0;
        end else begin
            if (pending) begin
                if (cnt == 1) begin
                    imem.imem_rsp_valid <= 1'b1;
                    imem.imem_rsp_data  <= mem_word(paddr);
                    imem.imem_rsp_err   <= err_en && paddr == err_addr;
                    pending             <= 1'b0;
                end else cnt <= cnt - 1;
            end
            if (imem.imem_req_valid && imem.imem_req_ready) begin
                if (lat == 1) begin
                    imem.imem_rsp_valid <= 1'b1;
                    imem.imem_rsp_data  <= mem_word(imem.imem_req_addr);
                    imem.imem_rsp_err   <= err_en && imem.imem_req_addr == err_addr;
                end else begin
                    pending <= 1'b1;
                    cnt     <= lat - 1;
                    paddr   <= imem.imem_req_addr;
                end
            end
            if (stray) begin
                imem.imem_rsp_valid <= 1'b1;
                imem.imem_rsp_data  <= 32'hdead_beef;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        out_ready = 1'b0;
        dnpc_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ok = out_valid === 1'b1;
    endtask

    task automatic accept(input logic [31:0] npc);
        out_ready = 1'b1;
        dnpc_valid = 1'b1;
        dnpc = npc;
        tick();
        out_ready = 1'b0;
        dnpc_valid = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        dnpc_valid = 1'b0;
        dnpc = '0;
        imem.imem_req_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        compared++; if (imem.imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL reset_req_valid got %b want 0", imem.imem_req_valid); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        compared++; if (pc !== RPC) begin mismatched++; $display("FAIL reset_pc got %h want %h", pc, RPC); end
        compared++; if (inst !== 32'h0) begin mismatched++; $display("FAIL reset_inst got %h want 0", inst); end
        compared++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin mismatched++; $display("FAIL reset_fault got %b/%h want 0/0", fetch_fault, fault_pc); end
        compared++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin mismatched++; $display("FAIL reset_cnt got %0d/%0d want 0/0", fetch_cnt, stall_cnt); end
        rst = 1'b0;
        #1;
        compared++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== RPC) begin mismatched++; $display("FAIL first_req got %b@%h want 1@%h", imem.imem_req_valid, imem.imem_req_addr, RPC); end
    endtask

    task automatic test_first_fetch();
        tick();
        compared++; if (imem.imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL wait_cycle got req %b out %b want 0 0", imem.imem_req_valid, out_valid); end
        tick();
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL first_out_valid got %b want 1", out_valid); end
        compared++; if (pc !== RPC || inst !== 32'h13) begin mismatched++; $display("FAIL first_out got %h/%h want %h/00000013", pc, inst, RPC); end
        compared++; if (stall_cnt !== 32'd0) begin mismatched++; $display("FAIL first_stall got %0d want 0", stall_cnt); end
        accept(RPC + 32'd4);
        compared++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== RPC + 32'd4) begin mismatched++; $display("FAIL next_req got %b@%h want 1@%h", imem.imem_req_valid, imem.imem_req_addr, RPC + 32'd4); end
        compared++; if (fetch_cnt !== 32'd1) begin mismatched++; $display("FAIL first_fetch_cnt got %0d want 1", fetch_cnt); end
    endtask

    task automatic test_stream();
        bit ok;
        logic [31:0] exp;
        lat = 3;
        do_reset(2);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            exp = RPC + 32'(4 * i);
            while (imem.imem_req_valid !== 1'b1 && n < 20) begin tick(); n++; end
            compared++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== exp) begin mismatched++; $display("FAIL stream_req%0d got %b@%h want 1@%h", i, imem.imem_req_valid, imem.imem_req_addr, exp); end
            wait_out(ok);
            compared++; if (!ok || pc !== exp || inst !== mem_word(exp)) begin mismatched++; $display("FAIL stream_out%0d got %b %h/%h want 1 %h/%h", i, ok, pc, inst, exp, mem_word(exp)); end
            dnpc = exp + 32'd4;
            dnpc_valid = 1'b1;
            tick();
            dnpc_valid = 1'b0;
        end
        out_ready = 1'b0;
        compared++; if (fetch_cnt !== 32'd3) begin mismatched++; $display("FAIL stream_fetch_cnt got %0d want 3", fetch_cnt); end
        compared++; if (stall_cnt !== 32'd6) begin mismatched++; $display("FAIL stream_stall_cnt got %0d want 6", stall_cnt); end
        lat = 1;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset(2);
        wait_out(ok);
        compared++; if (!ok || stall_cnt !== 32'd0) begin mismatched++; $display("FAIL bp_start got %b/%0d want 1/0", ok, stall_cnt); end
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++; if (out_valid !== 1'b1 || pc !== RPC || inst !== 32'h13) begin mismatched++; $display("FAIL bp_hold%0d got %b %h/%h want 1 %h/00000013", i, out_valid, pc, inst, RPC); end
        end
        compared++; if (stall_cnt !== 32'd4) begin mismatched++; $display("FAIL bp_stall got %0d want 4", stall_cnt); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        compared++; if (out_valid !== 1'b0 || imem.imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL npc_idle got out %b req %b want 0 0", out_valid, imem.imem_req_valid); end
        compared++; if (fetch_cnt !== 32'd1 || stall_cnt !== 32'd4) begin mismatched++; $display("FAIL npc_cnt got %0d/%0d want 1/4", fetch_cnt, stall_cnt); end
        tick();
        compared++; if (imem.imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL npc_wait got req %b want 0", imem.imem_req_valid); end
        dnpc = RPC + 32'h40;
        dnpc_valid = 1'b1;
        tick();
        dnpc_valid = 1'b0;
        compared++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== RPC + 32'h40 || pc !== RPC + 32'h40) begin mismatched++; $display("FAIL npc_req got %b@%h pc %h want 1@%h", imem.imem_req_valid, imem.imem_req_addr, pc, RPC + 32'h40); end
        compared++; if (stall_cnt !== 32'd4) begin mismatched++; $display("FAIL npc_stall got %0d want 4", stall_cnt); end
    endtask

    task automatic test_misaligned();
        bit ok;
        int n = 0;
        do_reset(2);
        wait_out(ok);
        accept(RPC + 32'h100);
        wait_out(ok);
        compared++; if (!ok || pc !== RPC + 32'h100 || inst !== 32'h0010_0013) begin mismatched++; $display("FAIL mis_pre got %b %h/%h want 1 %h/00100013", ok, pc, inst, RPC + 32'h100); end
        accept(RPC + 32'h102);
        compared++; if (fetch_fault !== 1'b1 || fault_pc !== RPC + 32'h102) begin mismatched++; $display("FAIL mis_fault got %b/%h want 1/%h", fetch_fault, fault_pc, RPC + 32'h102); end
        compared++; if (pc !== RPC + 32'h100 || out_valid !== 1'b0) begin mismatched++; $display("FAIL mis_pc got %h out %b want %h 0", pc, out_valid, RPC + 32'h100); end
        repeat (6) begin
            if (imem.imem_req_valid !== 1'b0 || out_valid !== 1'b0) n++;
            tick();
        end
        compared++; if (n !== 0 || fetch_fault !== 1'b1) begin mismatched++; $display("FAIL mis_quiet got %0d active cycles fault %b want 0 1", n, fetch_fault); end
        compared++; if (fetch_cnt !== 32'd2) begin mismatched++; $display("FAIL mis_cnt got %0d want 2", fetch_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        compared++; if (fetch_fault !== 1'b0 || pc !== RPC || fault_pc !== 32'h0) begin mismatched++; $display("FAIL mis_reset got %b %h %h want 0 %h 0", fetch_fault, pc, fault_pc, RPC); end
    endtask

    task automatic test_rsp_err();
        bit ok;
        int n = 0;
        int seen = 0;
        do_reset(2);
        err_en = 1'b1;
        err_addr = RPC + 32'h10;
        wait_out(ok);
        accept(RPC + 32'h10);
        while (fetch_fault !== 1'b1 && n < 20) begin
            if (out_valid === 1'b1) seen++;
            tick();
            n++;
        end
        compared++; if (fetch_fault !== 1'b1 || fault_pc !== RPC + 32'h10) begin mismatched++; $display("FAIL err_fault got %b/%h want 1/%h", fetch_fault, fault_pc, RPC + 32'h10); end
        compared++; if (seen !== 0 || out_valid !== 1'b0 || imem.imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL err_quiet got seen %0d out %b req %b want 0 0 0", seen, out_valid, imem.imem_req_valid); end
        compared++; if (fetch_cnt !== 32'd1) begin mismatched++; $display("FAIL err_cnt got %0d want 1", fetch_cnt); end
        err_en = 1'b0;
    endtask

    task automatic test_abort();
        bit ok;
        lat = 3;
        do_reset(2);
        tick();
        compared++; if (imem.imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL abort_wait got req %b want 0", imem.imem_req_valid); end
        rst = 1'b1;
        tick();
        compared++; if (imem.imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL abort_rst got req %b out %b want 0 0", imem.imem_req_valid, out_valid); end
        rst = 1'b0;
        #1;
        compared++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== RPC || fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin mismatched++; $display("FAIL abort_restart got %b@%h cnt %0d/%0d want 1@%h 0/0", imem.imem_req_valid, imem.imem_req_addr, fetch_cnt, stall_cnt, RPC); end
        imem.imem_req_ready = 1'b0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        compared++; if (imem.imem_req_valid !== 1'b1 || out_valid !== 1'b0 || inst !== 32'h0) begin mismatched++; $display("FAIL stray got req %b out %b inst %h want 1 0 0", imem.imem_req_valid, out_valid, inst); end
        compared++; if (stall_cnt !== 32'd0) begin mismatched++; $display("FAIL stray_stall got %0d want 0", stall_cnt); end
        lat = 1;
        imem.imem_req_ready = 1'b1;
        wait_out(ok);
        compared++; if (!ok || pc !== RPC || inst !== 32'h13) begin mismatched++; $display("FAIL abort_fetch got %b %h/%h want 1 %h/00000013", ok, pc, inst, RPC); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_stream();
        test_backpressure();
        test_misaligned();
        test_rsp_err();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
